// File: rtl/decode_issue_stage.sv
// Registered decode/issue stage: opcode decode, immediate extension, register
// scoreboard for RAW/WAW stalls, valid/ready handoff to execute, and flush.
module decode_issue_stage #(
  parameter int DATA_W    = 16,
  parameter int IMM_W     = 9,
  parameter int NUM_REGS  = 8,
  parameter int SEXT_IMM  = 0,
  parameter int REG0_ZERO = 1,
  localparam int RA_W     = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode_i,
  input  logic [RA_W-1:0]   rd_i,
  input  logic [RA_W-1:0]   rs1_i,
  input  logic [RA_W-1:0]   rs2_i,
  input  logic [IMM_W-1:0]  imm_i,
  input  logic              flush,
  input  logic              wb_valid,
  input  logic [RA_W-1:0]   wb_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              reg_write,
  output logic              mem_write,
  output logic              mem_to_reg,
  output logic              alu_src2,
  output logic              is_branch,
  output logic              illegal,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] imm_o,
  output logic [RA_W-1:0]   rd_o,
  output logic [RA_W-1:0]   rs1_o,
  output logic [RA_W-1:0]   rs2_o
);

  logic              dec_rw, dec_mw, dec_m2r, dec_src2, dec_br, dec_ill, dec_rs2, dec_rtype;
  logic [3:0]        dec_alu;
  logic [DATA_W-1:0] imm_ext, imm_d;

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic              out_valid_q;
  logic              rw_q, mw_q, m2r_q, src2_q, br_q, ill_q;
  logic [3:0]        alu_q;
  logic [DATA_W-1:0] imm_q;
  logic [RA_W-1:0]   rd_q, rs1_q, rs2_q;

  logic hazard, accept;

  always_comb begin
    dec_rw    = 1'b0;
    dec_mw    = 1'b0;
    dec_m2r   = 1'b0;
    dec_src2  = 1'b0;
    dec_br    = 1'b0;
    dec_ill   = 1'b0;
    dec_rs2   = 1'b0;
    dec_rtype = 1'b0;
    dec_alu   = 4'b0000;
    case (opcode_i)
      4'h0: begin dec_rw = 1'b1; dec_m2r = 1'b1; dec_src2 = 1'b1; end
      4'h1: begin dec_mw = 1'b1; dec_src2 = 1'b1; dec_rs2 = 1'b1; end
      4'h2: begin dec_rw = 1'b1; dec_rs2 = 1'b1; dec_rtype = 1'b1; end
      4'h3: begin dec_rw = 1'b1; dec_src2 = 1'b1; end
      4'h4: begin dec_rw = 1'b1; dec_rs2 = 1'b1; dec_rtype = 1'b1; dec_alu = 4'b0010; end
      4'h5: begin dec_rw = 1'b1; dec_src2 = 1'b1; dec_alu = 4'b0010; end
      4'h6: begin dec_rw = 1'b1; dec_rs2 = 1'b1; dec_rtype = 1'b1; dec_alu = 4'b0011; end
      4'h7: begin dec_rw = 1'b1; dec_rs2 = 1'b1; dec_rtype = 1'b1; dec_alu = 4'b1000; end
      4'h8: begin dec_rw = 1'b1; dec_src2 = 1'b1; dec_alu = 4'b0100; end
      4'h9: begin dec_rw = 1'b1; dec_src2 = 1'b1; dec_alu = 4'b0101; end
      4'hA: begin dec_br = 1'b1; dec_rs2 = 1'b1; dec_alu = 4'b0110; end
      4'hB: begin dec_br = 1'b1; dec_rs2 = 1'b1; dec_alu = 4'b1000; end
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    if (SEXT_IMM != 0) imm_ext = DATA_W'($signed(imm_i));
    else               imm_ext = DATA_W'(imm_i);
    imm_d = dec_rtype ? '0 : imm_ext;
  end

  // Register 0 is masked here so a hardwired-zero source never stalls.
  function automatic logic is_pend(input logic [RA_W-1:0] idx);
    is_pend = pend_q[idx] && !((REG0_ZERO != 0) && (idx == '0));
  endfunction

  assign hazard   = is_pend(rs1_i) || (dec_rs2 && is_pend(rs2_i)) || (dec_rw && is_pend(rd_i));
  assign in_ready = rst_n && !flush && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Priority: writeback clear, then flush kill, then issue set (set wins).
  always_comb begin
    pend_d = pend_q;
    if (wb_valid) pend_d[wb_rd] = 1'b0;
    if (flush && out_valid_q && rw_q) pend_d[rd_q] = 1'b0;
    if (accept && dec_rw && !((REG0_ZERO != 0) && (rd_i == '0))) pend_d[rd_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      rw_q        <= 1'b0;
      mw_q        <= 1'b0;
      m2r_q       <= 1'b0;
      src2_q      <= 1'b0;
      br_q        <= 1'b0;
      ill_q       <= 1'b0;
      alu_q       <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
    end else begin
      pend_q <= pend_d;
      if (accept) begin
        out_valid_q <= 1'b1;
        rw_q        <= dec_rw;
        mw_q        <= dec_mw;
        m2r_q       <= dec_m2r;
        src2_q      <= dec_src2;
        br_q        <= dec_br;
        ill_q       <= dec_ill;
        alu_q       <= dec_alu;
        imm_q       <= imm_d;
        rd_q        <= rd_i;
        rs1_q       <= rs1_i;
        rs2_q       <= rs2_i;
      end else if (flush || out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign reg_write  = rw_q;
  assign mem_write  = mw_q;
  assign mem_to_reg = m2r_q;
  assign alu_src2   = src2_q;
  assign is_branch  = br_q;
  assign illegal    = ill_q;
  assign alu_op     = alu_q;
  assign imm_o      = imm_q;
  assign rd_o       = rd_q;
  assign rs1_o      = rs1_q;
  assign rs2_o      = rs2_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench: decode table vectors plus hand-written hazard, stall,
// flush, collision and async-reset sequences.
module tb_decode_issue_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, flush, wb_valid, out_ready;
  logic [3:0] opcode_i;
  logic [2:0] rd_i, rs1_i, rs2_i, wb_rd;
  logic [8:0] imm_i;

  logic        in_ready, out_valid, reg_write, mem_write, mem_to_reg, alu_src2, is_branch, illegal;
  logic [3:0]  alu_op;
  logic [15:0] imm_o;
  logic [2:0]  rd_o, rs1_o, rs2_o;

  logic        s_in_ready, s_out_valid, s_reg_write, s_mem_write, s_mem_to_reg, s_alu_src2, s_is_branch, s_illegal;
  logic [3:0]  s_alu_op;
  logic [15:0] s_imm_o;
  logic [2:0]  s_rd_o, s_rs1_o, s_rs2_o;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  decode_issue_stage #(.DATA_W(16), .IMM_W(9), .NUM_REGS(8), .SEXT_IMM(0), .REG0_ZERO(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .reg_write(reg_write), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .alu_src2(alu_src2), .is_branch(is_branch), .illegal(illegal),
    .alu_op(alu_op), .imm_o(imm_o), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o)
  );

  decode_issue_stage #(.DATA_W(16), .IMM_W(9), .NUM_REGS(8), .SEXT_IMM(1), .REG0_ZERO(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
    .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .reg_write(s_reg_write), .mem_write(s_mem_write), .mem_to_reg(s_mem_to_reg),
    .alu_src2(s_alu_src2), .is_branch(s_is_branch), .illegal(s_illegal),
    .alu_op(s_alu_op), .imm_o(s_imm_o), .rd_o(s_rd_o), .rs1_o(s_rs1_o), .rs2_o(s_rs2_o)
  );

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic [8:0]  imm;
    logic        rw, mw, m2r, src2, br, ill;
    logic [3:0]  alu;
    logic [15:0] imm_z, imm_s;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [8:0] imm);
    opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm; in_valid = 1'b1;
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [2:0] rd, input logic [8:0] imm,
                              input logic [5:0] ctl, input logic [3:0] alu,
                              input logic [15:0] iz, input logic [15:0] is);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = 3'd2; v.rs2 = 3'd3; v.imm = imm;
    {v.rw, v.mw, v.m2r, v.src2, v.br, v.ill} = ctl;
    v.alu = alu; v.imm_z = iz; v.imm_s = is;
    return v;
  endfunction

  initial begin
    // ctl = {reg_write, mem_write, mem_to_reg, alu_src2, is_branch, illegal}
    vecs[0]  = mk(4'h0, 3'd1, 9'h1A5, 6'b101100, 4'b0000, 16'h01A5, 16'hFFA5);
    vecs[1]  = mk(4'h1, 3'd4, 9'h0A5, 6'b010100, 4'b0000, 16'h00A5, 16'h00A5);
    vecs[2]  = mk(4'h2, 3'd5, 9'h1A5, 6'b100000, 4'b0000, 16'h0000, 16'h0000);
    vecs[3]  = mk(4'h3, 3'd6, 9'h1A5, 6'b100100, 4'b0000, 16'h01A5, 16'hFFA5);
    vecs[4]  = mk(4'h4, 3'd7, 9'h1A5, 6'b100000, 4'b0010, 16'h0000, 16'h0000);
    vecs[5]  = mk(4'h5, 3'd1, 9'h100, 6'b100100, 4'b0010, 16'h0100, 16'hFF00);
    vecs[6]  = mk(4'h6, 3'd4, 9'h1A5, 6'b100000, 4'b0011, 16'h0000, 16'h0000);
    vecs[7]  = mk(4'h7, 3'd5, 9'h1A5, 6'b100000, 4'b1000, 16'h0000, 16'h0000);
    vecs[8]  = mk(4'h8, 3'd6, 9'h0FF, 6'b100100, 4'b0100, 16'h00FF, 16'h00FF);
    vecs[9]  = mk(4'h9, 3'd7, 9'h1A5, 6'b100100, 4'b0101, 16'h01A5, 16'hFFA5);
    vecs[10] = mk(4'hA, 3'd1, 9'h1A5, 6'b000010, 4'b0110, 16'h01A5, 16'hFFA5);
    vecs[11] = mk(4'hB, 3'd4, 9'h03C, 6'b000010, 4'b1000, 16'h003C, 16'h003C);
    vecs[12] = mk(4'hC, 3'd5, 9'h1A5, 6'b000001, 4'b0000, 16'h01A5, 16'hFFA5);
    vecs[13] = mk(4'hF, 3'd6, 9'h001, 6'b000001, 4'b0000, 16'h0001, 16'h0001);

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0; wb_rd = '0; out_ready = 1'b1;
    opcode_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0; imm_i = '0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_reg_write", 32'(reg_write), 0);
    chk("rst_imm_o", 32'(imm_o), 0);
    chk("rst_pend", 32'(dut.pend_q), 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 1);
      tick();
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 1);
      chk($sformatf("v%0d_ctl", i), 32'({reg_write, mem_write, mem_to_reg, alu_src2, is_branch, illegal}),
          32'({vecs[i].rw, vecs[i].mw, vecs[i].m2r, vecs[i].src2, vecs[i].br, vecs[i].ill}));
      chk($sformatf("v%0d_alu_op", i), 32'(alu_op), 32'(vecs[i].alu));
      chk($sformatf("v%0d_imm_z", i), 32'(imm_o), 32'(vecs[i].imm_z));
      chk($sformatf("v%0d_imm_s", i), 32'(s_imm_o), 32'(vecs[i].imm_s));
      chk($sformatf("v%0d_regs", i), 32'({rd_o, rs1_o, rs2_o}), 32'({vecs[i].rd, vecs[i].rs1, vecs[i].rs2}));
      chk($sformatf("v%0d_pend", i), 32'(dut.pend_q), vecs[i].rw ? (32'd1 << vecs[i].rd) : 32'd0);
      in_valid = 1'b0; wb_valid = 1'b1; wb_rd = vecs[i].rd;
      tick();
      wb_valid = 1'b0;
    end

    // ADDI rd=3 then dependent ADD stalls until writeback of r3
    drive(4'h3, 3'd3, 3'd1, 3'd0, 9'h1FF);
    tick();
    chk("addi_out_valid", 32'(out_valid), 1);
    chk("addi_imm_z", 32'(imm_o), 32'h01FF);
    chk("addi_imm_s", 32'(s_imm_o), 32'hFFFF);
    chk("addi_pend", 32'(dut.pend_q), 32'h08);
    drive(4'h2, 3'd6, 3'd3, 3'd2, 9'h000);
    #1;
    chk("raw_stall", 32'(in_ready), 0);
    wb_valid = 1'b1; wb_rd = 3'd3;
    #1;
    chk("raw_no_bypass", 32'(in_ready), 0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("raw_release", 32'(in_ready), 1);
    chk("raw_pend_clr", 32'(dut.pend_q), 0);
    tick();
    chk("add_out_valid", 32'(out_valid), 1);
    chk("add_regs", 32'({rd_o, rs1_o, rs2_o}), 32'({3'd6, 3'd3, 3'd2}));
    chk("add_pend", 32'(dut.pend_q), 32'h40);
    in_valid = 1'b0; wb_valid = 1'b1; wb_rd = 3'd6;
    tick();
    wb_valid = 1'b0;

    // SW held under backpressure, then back-to-back transfer
    out_ready = 1'b0;
    drive(4'h1, 3'd0, 3'd1, 3'd2, 9'h012);
    tick();
    drive(4'h3, 3'd4, 3'd1, 3'd0, 9'h005);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("hold%0d_valid", c), 32'(out_valid), 1);
      chk($sformatf("hold%0d_ctl", c), 32'({mem_write, reg_write}), 32'b10);
      chk($sformatf("hold%0d_imm", c), 32'(imm_o), 32'h0012);
      chk($sformatf("hold%0d_in_ready", c), 32'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", 32'(in_ready), 1);
    tick();
    chk("b2b_out_valid", 32'(out_valid), 1);
    chk("b2b_ctl", 32'({reg_write, mem_write, alu_src2}), 32'b101);
    chk("b2b_imm", 32'(imm_o), 32'h0005);
    chk("b2b_rd", 32'(rd_o), 4);
    in_valid = 1'b0;
    tick();
    chk("b2b_drain", 32'(out_valid), 0);
    wb_valid = 1'b1; wb_rd = 3'd4;
    tick();
    wb_valid = 1'b0;

    // illegal opcode sets no pending bit
    drive(4'hD, 3'd3, 3'd1, 3'd2, 9'h000);
    tick();
    chk("ill_flags", 32'({illegal, reg_write, mem_write}), 32'b100);
    chk("ill_pend", 32'(dut.pend_q), 0);
    in_valid = 1'b0;
    tick();

    // flush kills held LW and its pending bit
    out_ready = 1'b0;
    drive(4'h0, 3'd5, 3'd1, 3'd0, 9'h000);
    tick();
    chk("lw_pend", 32'(dut.pend_q), 32'h20);
    in_valid = 1'b0; flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 0);
    tick();
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_pend", 32'(dut.pend_q), 0);
    flush = 1'b0; out_ready = 1'b1;
    drive(4'h0, 3'd0, 3'd1, 3'd0, 9'h000);
    tick();
    chk("lw_r0_valid", 32'(out_valid), 1);
    chk("lw_r0_pend", 32'(dut.pend_q), 0);
    in_valid = 1'b0;
    tick();

    // same-cycle writeback and issue to r4: set wins; then async reset
    drive(4'h2, 3'd4, 3'd1, 3'd2, 9'h000);
    wb_valid = 1'b1; wb_rd = 3'd4;
    tick();
    chk("collide_pend", 32'(dut.pend_q), 32'h10);
    in_valid = 1'b0; wb_valid = 1'b0; out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_pend", 32'(dut.pend_q), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    chk("arst_bundle", 32'({reg_write, rd_o, rs1_o, rs2_o}), 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
